// File: rtl/score_pkg.sv
// Shared widths, converter state type and the active-low 7-segment table for the score display path.
package score_pkg;
    localparam int SCORE_W    = 10;
    localparam int BCD_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} conv_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/score_display_bin2bcd.sv
// Sequential double-dabble: one shift per clock, result and done pulse one edge after the last shift.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SCORE_W-1:0]        bin_in,
    input  logic                      start,
    output logic [4*BCD_DIGITS-1:0]   bcd,
    output logic                      done
);
    localparam int SH_W  = 4*BCD_DIGITS + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W);

    conv_state_t              r_state;
    logic [SH_W-1:0]          r_sh;
    logic [CNT_W-1:0]         r_cnt;
    logic [4*BCD_DIGITS-1:0]  r_bcd;
    logic                     r_done;
    logic [SH_W-1:0]          w_adj;

    always_comb begin
        w_adj = r_sh;
        for (int k = 0; k < BCD_DIGITS; k++)
            if (r_sh[SCORE_W+4*k +: 4] >= 4'd5)
                w_adj[SCORE_W+4*k +: 4] = r_sh[SCORE_W+4*k +: 4] + 4'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_sh    <= {{(4*BCD_DIGITS){1'b0}}, bin_in};
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_sh  <= {w_adj[SH_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(SCORE_W-1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_bcd   <= r_sh[SH_W-1 -: 4*BCD_DIGITS];
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;
endmodule

// File: rtl/score_display.sv
// Score change detector, BCD converter and 4-digit multiplexed 7-segment driver with leading-zero blanking.
module score_display
    import score_pkg::*;
#(
    parameter int REFRESH_DIV = 65536
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SCORE_W-1:0]       score_in,
    output logic [4*BCD_DIGITS-1:0]  bcd_out,
    output logic                     bcd_valid,
    output logic [BCD_DIGITS-1:0]    an,
    output logic [6:0]               seg,
    output logic                     dp
);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [SCORE_W-1:0]       r_last;
    logic                     r_busy;
    logic [CNT_W-1:0]         r_cnt;
    logic [1:0]               r_sel;
    logic [BCD_DIGITS-1:0]    r_an;
    logic [6:0]               r_seg;

    logic                     w_start, w_done, w_wrap, w_zero;
    logic [4*BCD_DIGITS-1:0]  w_bcd;
    logic [1:0]               w_sel_nxt;
    logic [BCD_DIGITS-1:0]    w_blank;
    logic [BCD_DIGITS-1:0]    w_one;

    // The converter is free again on the cycle its done pulse is visible.
    assign w_start = (score_in != r_last) && (!r_busy || w_done);

    bin2bcd_seq u_conv (
        .clk    (clk),
        .rst    (rst),
        .bin_in (score_in),
        .start  (w_start),
        .bcd    (w_bcd),
        .done   (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= '0;
            r_busy <= 1'b0;
        end else if (w_start) begin
            r_last <= score_in;
            r_busy <= 1'b1;
        end else if (w_done) begin
            r_busy <= 1'b0;
        end
    end

    assign w_wrap    = (r_cnt == CNT_W'(REFRESH_DIV-1));
    assign w_sel_nxt = w_wrap ? r_sel + 2'd1 : r_sel;
    assign w_one     = BCD_DIGITS'(1);

    always_comb begin
        w_blank = '0;
        w_zero  = 1'b1;
        for (int k = BCD_DIGITS-1; k >= 1; k--) begin
            w_zero     = w_zero && (w_bcd[4*k +: 4] == 4'd0);
            w_blank[k] = w_zero;
        end
    end

    // an/seg are recomputed every cycle from the next select so a new score shows without waiting a scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_sel <= 2'd0;
            r_an  <= 4'b1110;
            r_seg <= 7'b1000000;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_sel <= w_sel_nxt;
            r_an  <= ~(w_one << w_sel_nxt);
            r_seg <= w_blank[w_sel_nxt] ? SEG_BLANK : seg_encode(w_bcd[4*w_sel_nxt +: 4]);
        end
    end

    assign bcd_out   = w_bcd;
    assign bcd_valid = w_done;
    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = 1'b1;
endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: conversion table, back-to-back changes, refresh scan and mid-conversion reset.
module tb_score_display;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  score_in;
    logic [15:0] bcd_out;
    logic        bcd_valid;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [9:0]  score;
        logic [15:0] exp_bcd;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    score_display #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .score_in  (score_in),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Caller has just driven score_in after a negedge; the next posedge is the load edge.
    task automatic watch(input string name, input logic [15:0] exp);
        int first = -1;
        int pulses = 0;
        logic [15:0] got = 16'hxxxx;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (bcd_valid === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = j;
                    got = bcd_out;
                end
            end
        end
        chk({name, " latency"}, first, 11);
        chk({name, " pulses"}, pulses, 1);
        chk({name, " bcd"}, got, exp);
    endtask

    initial begin
        int t[2];
        logic [15:0] v[2];
        int np;
        logic [3:0] prev_an;
        logic [3:0] exp_an[4];
        logic [6:0] exp_seg[4];
        bit found;

        vecs[0] = '{10'd123,  16'h0123};
        vecs[1] = '{10'd1023, 16'h1023};
        vecs[2] = '{10'd0,    16'h0000};
        vecs[3] = '{10'd999,  16'h0999};
        vecs[4] = '{10'd512,  16'h0512};
        vecs[5] = '{10'd1,    16'h0001};

        rst = 1'b1;
        score_in = 10'd0;
        repeat (3) @(negedge clk);
        chk("rst bcd_out", bcd_out, 16'h0000);
        chk("rst bcd_valid", bcd_valid, 0);
        chk("rst an", an, 4'b1110);
        chk("rst seg", seg, 7'b1000000);
        chk("rst dp", dp, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            score_in = vecs[i].score;
            watch($sformatf("conv%0d", vecs[i].score), vecs[i].exp_bcd);
        end

        // 5 then 6 while the first conversion is still running
        @(negedge clk);
        score_in = 10'd5;
        np = 0;
        t[0] = -1; t[1] = -1; v[0] = 16'hxxxx; v[1] = 16'hxxxx;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 2) score_in = 10'd6;
            if (bcd_valid === 1'b1) begin
                if (np < 2) begin
                    t[np] = j;
                    v[np] = bcd_out;
                end
                np++;
            end
        end
        chk("b2b pulses", np, 2);
        chk("b2b first latency", t[0], 11);
        chk("b2b first bcd", v[0], 16'h0005);
        chk("b2b spacing", t[1] - t[0], 12);
        chk("b2b second bcd", v[1], 16'h0006);

        // refresh scan with score 7
        @(negedge clk);
        score_in = 10'd7;
        watch("conv7", 16'h0007);
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111};
        found = 1'b0;
        prev_an = an;
        for (int j = 0; j < 40 && !found; j++) begin
            @(negedge clk);
            if (prev_an != 4'b1110 && an == 4'b1110) found = 1'b1;
            prev_an = an;
        end
        chk("scan start found", found, 1);
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            chk($sformatf("scan an %0d", j), an, exp_an[j/4]);
            chk($sformatf("scan seg %0d", j), seg, exp_seg[j/4]);
        end
        chk("scan dp", dp, 1);

        // reset in the middle of converting 100
        @(negedge clk);
        score_in = 10'd100;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst bcd_out", bcd_out, 16'h0000);
        chk("midrst bcd_valid", bcd_valid, 0);
        chk("midrst an", an, 4'b1110);
        chk("midrst seg", seg, 7'b1000000);
        @(negedge clk);
        chk("midrst held bcd_out", bcd_out, 16'h0000);
        rst = 1'b0;
        watch("conv100 after rst", 16'h0100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
